// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared constants and entry types for the reorder buffer
package reorder_buffer_pkg;

    localparam int ROB_ENTRY_SIZE = 4;

    // Destination register code meaning "no architectural write"
    localparam logic [5:0] NULL_REG = 6'd32;

    typedef struct packed {
        logic [5:0]  rd;
        logic        is_store;
        logic        is_br;
        logic        pred;
        logic [31:0] pc;
    } rob_meta_t;

    function automatic logic [31:0] link_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with tag allocation, result capture and mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ENTRY_SIZE = ROB_ENTRY_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,

    input  logic                  issue_valid,
    input  logic [5:0]            issue_rd,
    input  logic                  issue_is_store,
    input  logic                  issue_is_br,
    input  logic [31:0]           issue_pc,
    input  logic                  issue_pred,
    output logic                  rob_full,
    output logic [ENTRY_SIZE:0]   rob_new_entry,

    input  logic                  rs_broadcast,
    input  logic [ENTRY_SIZE:0]   rs_entry,
    input  logic [31:0]           rs_result,
    input  logic                  rs_taken,
    input  logic [31:0]           rs_target,

    input  logic                  lsb_broadcast,
    input  logic [ENTRY_SIZE:0]   lsb_entry,
    input  logic [31:0]           lsb_result,

    input  logic [ENTRY_SIZE:0]   qj_entry,
    input  logic [ENTRY_SIZE:0]   qk_entry,
    output logic                  qj_ready,
    output logic                  qk_ready,
    output logic [31:0]           qj_value,
    output logic [31:0]           qk_value,

    output logic                  rob_commit,
    output logic [ENTRY_SIZE:0]   rob_entry,
    output logic [5:0]            rob_des,
    output logic [31:0]           rob_result,
    output logic                  store_commit,
    output logic                  roll_back,
    output logic [31:0]           rollback_pc,
    output logic                  bp_update,
    output logic [31:0]           bp_pc,
    output logic                  bp_taken
);

    localparam int DEPTH = 1 << ENTRY_SIZE;
    // The null tag and the full count share one bit pattern: only the top bit set
    localparam logic [ENTRY_SIZE:0]   ENTRY_NULL = {1'b1, {ENTRY_SIZE{1'b0}}};
    localparam logic [ENTRY_SIZE-1:0] PTR_ONE    = {{(ENTRY_SIZE-1){1'b0}}, 1'b1};

    rob_meta_t             r_meta   [DEPTH];
    logic                  r_ready  [DEPTH];
    logic [31:0]           r_value  [DEPTH];
    logic                  r_taken  [DEPTH];
    logic [31:0]           r_target [DEPTH];

    logic [ENTRY_SIZE-1:0] r_head;
    logic [ENTRY_SIZE-1:0] r_tail;
    logic [ENTRY_SIZE:0]   r_count;

    logic                  r_rob_commit;
    logic [ENTRY_SIZE:0]   r_rob_entry;
    logic [5:0]            r_rob_des;
    logic [31:0]           r_rob_result;
    logic                  r_store_commit;
    logic                  r_roll_back;
    logic [31:0]           r_rollback_pc;
    logic                  r_bp_update;
    logic [31:0]           r_bp_pc;
    logic                  r_bp_taken;

    rob_meta_t             w_head_meta;
    logic                  w_full;
    logic                  w_commit;
    logic                  w_mispredict;
    logic [31:0]           w_head_link;
    logic                  w_issue;
    logic                  w_rs_hit;
    logic                  w_lsb_hit;
    logic [ENTRY_SIZE:0]   w_count_next;
    logic                  w_qj_ready;
    logic                  w_qk_ready;
    logic [31:0]           w_qj_value;
    logic [31:0]           w_qk_value;

    assign w_head_meta  = r_meta[r_head];
    assign w_full       = (r_count == ENTRY_NULL);
    // Commit looks only at registered readiness, so a same-edge broadcast to the head waits one cycle
    assign w_commit     = (r_count != '0) && r_ready[r_head];
    assign w_mispredict = w_commit && w_head_meta.is_br && (r_taken[r_head] != w_head_meta.pred);
    assign w_head_link  = link_pc(w_head_meta.pc);
    // The front end is still on the wrong path during the flush edge and the cycle after it
    assign w_issue      = issue_valid && !w_full && !r_roll_back && !w_mispredict;
    assign w_rs_hit     = rs_broadcast && !rs_entry[ENTRY_SIZE];
    assign w_lsb_hit    = lsb_broadcast && !lsb_entry[ENTRY_SIZE];
    assign w_count_next = r_count + (ENTRY_SIZE+1)'(w_issue) - (ENTRY_SIZE+1)'(w_commit);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ready[i] <= 1'b0;
            end
            r_rob_commit   <= 1'b0;
            r_rob_entry    <= ENTRY_NULL;
            r_rob_des      <= NULL_REG;
            r_rob_result   <= '0;
            r_store_commit <= 1'b0;
            r_roll_back    <= 1'b0;
            r_rollback_pc  <= '0;
            r_bp_update    <= 1'b0;
            r_bp_pc        <= '0;
            r_bp_taken     <= 1'b0;
        end else if (rdy_in) begin
            r_rob_commit   <= w_commit;
            r_store_commit <= w_commit && w_head_meta.is_store;
            r_roll_back    <= w_mispredict;
            r_bp_update    <= w_commit && w_head_meta.is_br;

            if (w_commit) begin
                r_rob_entry  <= {1'b0, r_head};
                r_rob_des    <= w_head_meta.rd;
                r_rob_result <= w_mispredict ? w_head_link : r_value[r_head];
                r_bp_pc      <= w_head_meta.pc;
                r_bp_taken   <= r_taken[r_head];
            end

            if (w_mispredict) begin
                r_rollback_pc <= r_taken[r_head] ? r_target[r_head] : w_head_link;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_ready[i] <= 1'b0;
                end
            end else begin
                // Retired values now live in the register file, so the slot stops answering queries
                if (w_commit) begin
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + PTR_ONE;
                end
                if (w_lsb_hit) begin
                    r_ready[lsb_entry[ENTRY_SIZE-1:0]] <= 1'b1;
                    r_value[lsb_entry[ENTRY_SIZE-1:0]] <= lsb_result;
                end
                if (w_rs_hit) begin
                    r_ready[rs_entry[ENTRY_SIZE-1:0]]  <= 1'b1;
                    r_value[rs_entry[ENTRY_SIZE-1:0]]  <= rs_result;
                    r_taken[rs_entry[ENTRY_SIZE-1:0]]  <= rs_taken;
                    r_target[rs_entry[ENTRY_SIZE-1:0]] <= rs_target;
                end
                if (w_issue) begin
                    r_meta[r_tail]  <= '{rd: issue_rd, is_store: issue_is_store, is_br: issue_is_br,
                                         pred: issue_pred, pc: issue_pc};
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + PTR_ONE;
                end
                r_count <= w_count_next;
            end
        end
    end

    // Operand lookup: stored result first, then same-cycle broadcasts with RS taking priority
    always_comb begin
        w_qj_ready = 1'b0;
        w_qj_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (qj_entry == (ENTRY_SIZE+1)'(i) && r_ready[i]) begin
                w_qj_ready = 1'b1;
                w_qj_value = r_value[i];
            end
        end
        if (w_lsb_hit && lsb_entry == qj_entry) begin
            w_qj_ready = 1'b1;
            w_qj_value = lsb_result;
        end
        if (w_rs_hit && rs_entry == qj_entry) begin
            w_qj_ready = 1'b1;
            w_qj_value = rs_result;
        end
    end

    always_comb begin
        w_qk_ready = 1'b0;
        w_qk_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (qk_entry == (ENTRY_SIZE+1)'(i) && r_ready[i]) begin
                w_qk_ready = 1'b1;
                w_qk_value = r_value[i];
            end
        end
        if (w_lsb_hit && lsb_entry == qk_entry) begin
            w_qk_ready = 1'b1;
            w_qk_value = lsb_result;
        end
        if (w_rs_hit && rs_entry == qk_entry) begin
            w_qk_ready = 1'b1;
            w_qk_value = rs_result;
        end
    end

    assign rob_full      = w_full;
    assign rob_new_entry = {1'b0, r_tail};
    assign qj_ready      = w_qj_ready;
    assign qj_value      = w_qj_value;
    assign qk_ready      = w_qk_ready;
    assign qk_value      = w_qk_value;
    assign rob_commit    = r_rob_commit;
    assign rob_entry     = r_rob_entry;
    assign rob_des       = r_rob_des;
    assign rob_result    = r_rob_result;
    assign store_commit  = r_store_commit;
    assign roll_back     = r_roll_back;
    assign rollback_pc   = r_rollback_pc;
    assign bp_update     = r_bp_update;
    assign bp_pc         = r_bp_pc;
    assign bp_taken      = r_bp_taken;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer against a queue-level reference model
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int         DEPTH = 16;
    localparam logic [4:0] ENULL = 5'd16;
    localparam logic [111:0] RESET_VEC = {1'b0, 5'd16, 6'd32, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_in, rdy_in, issue_valid, issue_is_store, issue_is_br, issue_pred;
    logic [5:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        rob_full;
    logic [4:0]  rob_new_entry;
    logic        rs_broadcast, rs_taken, lsb_broadcast;
    logic [4:0]  rs_entry, lsb_entry, qj_entry, qk_entry;
    logic [31:0] rs_result, rs_target, lsb_result;
    logic        qj_ready, qk_ready;
    logic [31:0] qj_value, qk_value;
    logic        rob_commit, store_commit, roll_back, bp_update, bp_taken;
    logic [4:0]  rob_entry;
    logic [5:0]  rob_des;
    logic [31:0] rob_result, rollback_pc, bp_pc;

    reorder_buffer #(.ENTRY_SIZE(4)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_store(issue_is_store),
        .issue_is_br(issue_is_br), .issue_pc(issue_pc), .issue_pred(issue_pred),
        .rob_full(rob_full), .rob_new_entry(rob_new_entry),
        .rs_broadcast(rs_broadcast), .rs_entry(rs_entry), .rs_result(rs_result),
        .rs_taken(rs_taken), .rs_target(rs_target),
        .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
        .qj_entry(qj_entry), .qk_entry(qk_entry), .qj_ready(qj_ready), .qk_ready(qk_ready),
        .qj_value(qj_value), .qk_value(qk_value),
        .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_des(rob_des), .rob_result(rob_result),
        .store_commit(store_commit), .roll_back(roll_back), .rollback_pc(rollback_pc),
        .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken)
    );

    typedef struct packed {
        logic [4:0]  tag;
        logic [5:0]  rd;
        logic        is_store, is_br, pred, ready, taken;
        logic [31:0] pc, value, target;
    } m_ent_t;

    typedef struct packed {
        logic        rst, commit, store, rb, br, taken;
        logic [4:0]  tag;
        logic [5:0]  rd;
        logic [31:0] result, rbpc, pc;
    } exp_t;

    m_ent_t mq[$];
    exp_t   eq[$];
    int     m_tail  = 0;
    bit     m_block = 0;
    int     errors  = 0;
    int     checks  = 0;
    int     n_seen  = 0;
    bit     mon_on  = 0;
    bit     edge_live = 0, edge_rst = 0, edge_en = 0;
    logic [111:0] out_vec, prev_out;
    exp_t   me;

    assign out_vec = {rob_commit, rob_entry, rob_des, rob_result, store_commit, roll_back,
                      rollback_pc, bp_update, bp_pc, bp_taken};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock edge, applying reset, then commit, broadcasts, issue
    function automatic void model_edge();
        exp_t   e = '0;
        m_ent_t h, t;
        int     occ = mq.size();
        bit     flush = 0;
        if (rst_in) begin
            mq.delete();
            m_tail  = 0;
            m_block = 0;
            e.rst   = 1;
            eq.push_back(e);
            return;
        end
        if (!rdy_in) return;
        if (occ > 0 && mq[0].ready) begin
            h = mq.pop_front();
            e.commit = 1; e.tag = h.tag; e.rd = h.rd; e.store = h.is_store;
            e.br = h.is_br; e.pc = h.pc; e.taken = h.taken;
            e.rb = h.is_br && (h.taken != h.pred);
            e.result = e.rb ? h.pc + 32'd4 : h.value;
            e.rbpc = h.taken ? h.target : h.pc + 32'd4;
            if (e.rb) begin
                mq.delete();
                m_tail = 0;
                flush  = 1;
            end
        end
        if (!flush) begin
            foreach (mq[i]) begin
                t = mq[i];
                if (lsb_broadcast && t.tag == lsb_entry) begin t.ready = 1; t.value = lsb_result; end
                if (rs_broadcast && t.tag == rs_entry) begin
                    t.ready = 1; t.value = rs_result; t.taken = rs_taken; t.target = rs_target;
                end
                mq[i] = t;
            end
            if (issue_valid && occ < DEPTH && !m_block) begin
                t = '0;
                t.tag = 5'(m_tail); t.rd = issue_rd; t.is_store = issue_is_store;
                t.is_br = issue_is_br; t.pred = issue_pred; t.pc = issue_pc;
                mq.push_back(t);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        m_block = flush;
        eq.push_back(e);
    endfunction

    function automatic void mquery(input logic [4:0] q, output logic r, output logic [31:0] v);
        r = 0; v = 0;
        if (q == ENULL) return;
        if (rs_broadcast && rs_entry == q) begin r = 1; v = rs_result; return; end
        if (lsb_broadcast && lsb_entry == q) begin r = 1; v = lsb_result; return; end
        foreach (mq[i]) if (mq[i].tag == q && mq[i].ready) begin r = 1; v = mq[i].value; end
    endfunction

    task automatic step();
        logic        r;
        logic [31:0] v;
        #1;
        chk("rob_full", rob_full, (mq.size() == DEPTH));
        chk("rob_new_entry", rob_new_entry, m_tail);
        mquery(qj_entry, r, v);
        chk("qj_ready", qj_ready, r);
        chk("qj_value", qj_value, v);
        mquery(qk_entry, r, v);
        chk("qk_ready", qk_ready, r);
        chk("qk_value", qk_value, v);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = NULL_REG; issue_is_store = 0; issue_is_br = 0;
        issue_pc = 0; issue_pred = 0;
        rs_broadcast = 0; rs_entry = ENULL; rs_result = 0; rs_taken = 0; rs_target = 0;
        lsb_broadcast = 0; lsb_entry = ENULL; lsb_result = 0;
        qj_entry = ENULL; qk_entry = ENULL;
    endtask

    task automatic do_issue(input logic [5:0] rd, input logic st, input logic br,
                            input logic [31:0] pc, input logic pred);
        issue_valid = 1; issue_rd = rd; issue_is_store = st; issue_is_br = br;
        issue_pc = pc; issue_pred = pred;
    endtask

    task automatic rs_bc(input logic [4:0] tag, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
        rs_broadcast = 1; rs_entry = tag; rs_result = val; rs_taken = tk; rs_target = tgt;
    endtask

    task automatic rand_cycle();
        int          cand[$];
        int          a, b, kind;
        logic [31:0] pc;
        idle_inputs();
        rst_in = ($urandom_range(0, 399) == 0);
        rdy_in = ($urandom_range(0, 7) != 0);
        pc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 2) != 0) begin
            kind = $urandom_range(0, 9);
            if (kind < 2)      do_issue(NULL_REG, 1, 0, pc, 0);
            else if (kind < 4) do_issue((kind == 3) ? 6'($urandom_range(1, 31)) : NULL_REG, 0, 1, pc,
                                        1'($urandom_range(0, 1)));
            else               do_issue(($urandom_range(0, 7) == 0) ? NULL_REG : 6'($urandom_range(0, 31)),
                                        0, 0, pc, 0);
        end
        a = -1;
        foreach (mq[i]) if (!mq[i].ready) cand.push_back(i);
        if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
            a = cand[$urandom_range(0, cand.size() - 1)];
            rs_bc(mq[a].tag, $urandom,
                  mq[a].is_br ? (($urandom_range(0, 5) == 0) ? ~mq[a].pred : mq[a].pred) : 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FFFC);
        end
        cand.delete();
        foreach (mq[i]) if (!mq[i].ready && !mq[i].is_br && i != a) cand.push_back(i);
        if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
            b = cand[$urandom_range(0, cand.size() - 1)];
            lsb_broadcast = 1; lsb_entry = mq[b].tag; lsb_result = $urandom;
        end
        qj_entry = 5'($urandom_range(0, 16));
        qk_entry = (rs_broadcast && $urandom_range(0, 1) == 1) ? rs_entry : 5'($urandom_range(0, 16));
        step();
    endtask

    always @(posedge clk) begin
        edge_rst  = rst_in;
        edge_en   = rdy_in;
        edge_live = mon_on;
    end

    // Monitor: each live edge pops one expectation; frozen edges must leave every output untouched
    always @(negedge clk) begin
        if (edge_live) begin
            if (edge_rst || edge_en) begin
                if (rob_commit && !edge_rst) n_seen++;
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_underflow at %0t", $time);
                end else begin
                    me = eq.pop_front();
                    if (me.rst) chk("reset_outputs", out_vec, RESET_VEC);
                    else begin
                        chk("pulses", {rob_commit, store_commit, roll_back, bp_update},
                            {me.commit, me.store, me.rb, me.br});
                        if (me.commit) begin
                            chk("rob_entry", rob_entry, me.tag);
                            chk("rob_des", rob_des, me.rd);
                            chk("rob_result", rob_result, me.result);
                            if (me.br) begin
                                chk("bp_pc", bp_pc, me.pc);
                                chk("bp_taken", bp_taken, me.taken);
                            end
                            if (me.rb) chk("rollback_pc", rollback_pc, me.rbpc);
                        end
                    end
                end
            end else begin
                chk("hold_when_frozen", out_vec, prev_out);
            end
        end
        prev_out = out_vec;
    end

    initial begin
        int base;
        rst_in = 1; rdy_in = 1;
        idle_inputs();
        @(negedge clk);
        mon_on = 1;
        step(); step();
        rst_in = 0;

        // In-order retirement with out-of-order completion
        for (int k = 0; k < 3; k++) begin idle_inputs(); do_issue(6'(5 + k), 0, 0, 32'h40 + 32'(4 * k), 0); step(); end
        idle_inputs(); rs_bc(5'd1, 32'h1111, 0, 0); step();
        idle_inputs(); step(); step();
        idle_inputs(); rs_bc(5'd0, 32'h1000, 0, 0); step();
        idle_inputs(); repeat (4) step();

        // Fill, drop on full, wrap
        rst_in = 1; idle_inputs(); step(); rst_in = 0;
        for (int k = 0; k < 16; k++) begin idle_inputs(); do_issue(6'(k), 0, 0, 32'(k * 4), 0); step(); end
        #2; chk("full_after_16", rob_full, 1'b1);
        idle_inputs(); do_issue(6'd20, 0, 0, 32'h800, 0); step();
        #2; chk("drop_when_full", rob_new_entry, 5'd0);
        idle_inputs(); rs_bc(5'd0, 32'hA0, 0, 0); step();
        idle_inputs(); rs_bc(5'd1, 32'hA1, 0, 0); step();
        #2; chk("wrap_tag", rob_new_entry, 5'd0);
        idle_inputs(); do_issue(6'd21, 0, 0, 32'h900, 0); step();
        idle_inputs(); rs_bc(5'd2, 32'hA2, 0, 0); step();
        idle_inputs(); do_issue(6'd22, 0, 0, 32'h904, 0); step();
        idle_inputs(); repeat (3) step();

        // Mispredicted branch flushes and restarts allocation at tag 0
        rst_in = 1; idle_inputs(); step(); rst_in = 0;
        idle_inputs(); do_issue(NULL_REG, 0, 1, 32'h100, 0); step();
        idle_inputs(); do_issue(6'd3, 0, 0, 32'h104, 0); step();
        idle_inputs(); do_issue(6'd4, 0, 0, 32'h108, 0); step();
        idle_inputs(); rs_bc(5'd0, 32'h0, 1, 32'h200); step();
        idle_inputs(); step();
        #2;
        chk("roll_back", roll_back, 1'b1);
        chk("rollback_pc_0x200", rollback_pc, 32'h200);
        chk("bp_taken_1", {bp_update, bp_taken}, 2'b11);
        idle_inputs(); do_issue(6'd9, 0, 0, 32'h200, 0); step();
        idle_inputs(); do_issue(6'd9, 0, 0, 32'h200, 0); step();
        #2; chk("tag0_after_flush", rob_new_entry, 5'd1);

        // Same-cycle bypass on operand lookup
        rst_in = 1; idle_inputs(); step(); rst_in = 0;
        for (int k = 0; k < 4; k++) begin idle_inputs(); do_issue(6'(10 + k), 0, 0, 32'(k * 4), 0); step(); end
        idle_inputs(); rs_bc(5'd3, 32'hDEAD, 0, 0); qj_entry = 5'd3; qk_entry = 5'd2;
        #2;
        chk("qj_bypass", {qj_ready, qj_value}, {1'b1, 32'hDEAD});
        chk("qk_not_ready", {qk_ready, qk_value}, 33'd0);
        step();
        idle_inputs(); qj_entry = 5'd3; step();

        // Frozen commit pulse is seen exactly once
        base = n_seen;
        idle_inputs(); rs_bc(5'd0, 32'hA, 0, 0); step();
        idle_inputs(); step();
        rdy_in = 0; repeat (3) step();
        rdy_in = 1; step();
        #2; chk("single_commit", n_seen - base, 1);

        // Store retirement, then reset with a non-empty queue
        rst_in = 1; idle_inputs(); step(); rst_in = 0;
        idle_inputs(); do_issue(NULL_REG, 1, 0, 32'h300, 0); step();
        idle_inputs(); lsb_broadcast = 1; lsb_entry = 5'd0; lsb_result = 32'h55; step();
        idle_inputs(); step();
        #2; chk("store_commit", {store_commit, rob_des}, {1'b1, NULL_REG});
        for (int k = 0; k < 3; k++) begin idle_inputs(); do_issue(6'(k), 0, 0, 32'h0, 0); step(); end
        rst_in = 1; idle_inputs(); step(); rst_in = 0;

        for (int c = 0; c < 3000; c++) rand_cycle();

        rst_in = 0; rdy_in = 1; idle_inputs();
        repeat (3) step();
        #2; chk("scoreboard_drained", eq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
